tia_biphase_checker: RTL and testbench
======================================

Name: tia_biphase_checker

Overview:
- Receiving end of the TIA two-phase clock interface: consumes phi1/phi2 as driven by tia_biphase_clock and consumed by latch cells such as tia_d1r.
- Tracks the phi1 -> gap -> phi2 -> gap sequence in the master clk domain and counts completed phase cycles.
- Raises sticky error flags on overlap, ordering, width and stuck faults, and asserts lock after a run of clean cycles.
- Serves as a synthesizable monitor for sims and FPGA bring-up.

Parameters:
- HIGH_W, 1: required phi1/phi2 high width, in clk cycles.
- GAP_W, 1: required low gap after each phase before the other phase rises, in clk cycles.
- LOCK_CYCLES, 4: consecutive clean cycles required to assert locked.
- TIMEOUT, 16: maximum cycles in any tracking state before err_stuck.
- CNT_W, 16: cycle_count width.

Ports:
- clk  in  1  master clock, same net as the biphase generator clk.
- rl  in  1  reset, asynchronous, active-low.
- phi1  in  1  phase-1 clock under check; synchronous to clk.
- phi2  in  1  phase-2 clock under check; synchronous to clk.
- err_clr  in  1  synchronous clear of the sticky error flags.
- locked  out  1  LOCK_CYCLES consecutive clean cycles seen, no error since.
- tick  out  1  one-clk pulse on each completed cycle (G2 -> P1).
- cycle_count  out  CNT_W  completed-cycle counter; wraps to 0.
- err_overlap  out  1  sticky: phi1 and phi2 sampled high together.
- err_order  out  1  sticky: a phase rose out of sequence.
- err_width  out  1  sticky: high or gap width differed from HIGH_W / GAP_W.
- err_stuck  out  1  sticky: TIMEOUT reached with no transition.

Behaviour:
- Reset (rl=0, async): state=HUNT; cnt=0; good_run=0; p1_q/p2_q=0. All outputs 0. Deassertion is taken on the next posedge.
- Input capture:
  - phi1/phi2 are registered into p1_q/p2_q each posedge. The FSM acts on the registered values.
  - Any FSM, flag or output response appears at the 2nd posedge after the input change.
- States: HUNT, P1, G1, P2, G2. cnt counts samples in the current state; it is set to 1 on entry and saturates at TIMEOUT.
- HUNT: p1_q=1 and p2_q=0 -> P1. All other samples stay in HUNT; no timeout applies here.
- P1:
  - p1_q=1: cnt++.
  - p1_q=0: check cnt==HIGH_W (else err_width), then -> G1.
- G1:
  - both low: cnt++.
  - p2_q=1: check cnt==GAP_W (else err_width), then -> P2.
  - p1_q=1: err_order, -> HUNT.
- P2: same as P1 with phi2 in place of phi1; falls to G2.
- G2:
  - both low: cnt++.
  - p1_q=1: check the gap width, then -> P1. This transition is cycle completion: tick=1 and cycle_count++.
  - p2_q=1: err_order, -> HUNT.
- Overlap: p1_q=p2_q=1 in any state (HUNT included) sets err_overlap and forces HUNT. Overlap takes priority over all other checks in the same cycle.
- Stuck: cnt==TIMEOUT in P1/G1/P2/G2 sets err_stuck and forces HUNT.
- Width error: tracking continues, but the current cycle is marked bad.
- good_run:
  - Increments, saturating at LOCK_CYCLES, on a completion where the cycle was clean.
  - Cleared to 0 on any error event or any entry to HUNT.
- locked = (good_run==LOCK_CYCLES), registered. It drops at the same edge the error flag sets.
- Sticky flags:
  - err_clr=1 clears all four flags at the next posedge.
  - A new error in the same cycle as err_clr wins; that flag reads 1.
  - err_clr does not affect locked, good_run or cycle_count.
- cycle_count wraps from 2^CNT_W-1 to 0 with no flag.
- Reset asserted mid-cycle: immediate return to reset values. After release, the block re-hunts and the first completion takes a full phi1..phi1 cycle.

Test Plan:
- Nominal (defaults): generator pattern phi1 1clk, gap 1, phi2 1clk, gap 1, for 10 cycles -> tick every 4 clk; cycle_count=9 after the 10th phi1 rise; locked=1 from the 4th completion; all err_*=0.
- Overlap: after lock, hold phi1=phi2=1 for 1 clk -> err_overlap=1 and locked=0 two edges later, state HUNT. Nominal pattern resumes -> locked=1 again after 4 more completions; err_overlap stays 1 until err_clr.
- Width: stretch one phi2 high to 2 clk -> err_width=1, locked=0, tick still pulses for that cycle, cycle_count still increments.
- Order and stuck:
  - phi1 rises in G1 instead of phi2 -> err_order=1.
  - Hold phi1 high 20 clk -> err_stuck=1 at cnt=16.
  - err_clr pulse -> all flags 0 next edge.
- Clear collision and wrap:
  - err_clr in the same cycle as a fresh overlap -> err_overlap=1.
  - CNT_W=4, 17 cycles -> cycle_count wraps 15 -> 0.
- Async reset: assert rl between clk edges mid-P2 -> all outputs 0 immediately. Release -> no tick until the second phi1 rise.

Source files
------------

// File: rtl/tia_biphase_checker.sv
`default_nettype none
// ============================================================================
// Module   : tia_biphase_checker
// Brief    : Monitors a TIA two-phase clock pair (phi1/phi2) in the master
//            clk domain. It tracks the phi1 -> gap -> phi2 -> gap sequence,
//            counts completed cycles, raises sticky fault flags and reports
//            lock after a run of clean cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tia_biphase_checker #(
    parameter int HIGH_W      = 1,
    parameter int GAP_W       = 1,
    parameter int LOCK_CYCLES = 4,
    parameter int TIMEOUT     = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rl,
    input  logic             phi1,
    input  logic             phi2,
    input  logic             err_clr,
    output logic             locked,
    output logic             tick,
    output logic [CNT_W-1:0] cycle_count,
    output logic             err_overlap,
    output logic             err_order,
    output logic             err_width,
    output logic             err_stuck
);

    // Width of the per-state sample counter and of the clean-run counter.
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(LOCK_CYCLES + 1);

    localparam logic [CW-1:0]    C_CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]    C_TIMEOUT   = CW'(TIMEOUT);
    localparam logic [CW-1:0]    C_HIGH_W    = CW'(HIGH_W);
    localparam logic [CW-1:0]    C_GAP_W     = CW'(GAP_W);
    localparam logic [GW-1:0]    C_RUN_ONE   = GW'(1);
    localparam logic [GW-1:0]    C_LOCK      = GW'(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] C_CYC_ZERO  = '0;

    typedef enum logic [2:0] {
        S_HUNT = 3'd0,
        S_P1   = 3'd1,
        S_G1   = 3'd2,
        S_P2   = 3'd3,
        S_G2   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    good_run_q, good_run_d;
    logic             bad_q, bad_d;
    logic             p1_q, p1_d;
    logic             p2_q, p2_d;
    logic             locked_q, locked_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic             err_overlap_q, err_overlap_d;
    logic             err_order_q, err_order_d;
    logic             err_width_q, err_width_d;
    logic             err_stuck_q, err_stuck_d;

    logic             ev_overlap;
    logic             ev_order;
    logic             ev_width;
    logic             ev_stuck;
    logic             complete;
    logic             to_hunt;

    // Sequence tracking, fault detection and next values of every register.
    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == C_TIMEOUT) ? cnt_q : cnt_q + C_CNT_ONE;
        good_run_d = good_run_q;
        bad_d      = bad_q;
        ev_overlap = 1'b0;
        ev_order   = 1'b0;
        ev_width   = 1'b0;
        ev_stuck   = 1'b0;
        complete   = 1'b0;
        to_hunt    = 1'b0;

        // Overlap beats everything, then a timeout in a tracking state.
        if (p1_q && p2_q) begin
            ev_overlap = 1'b1;
            to_hunt    = 1'b1;
        end else if ((state_q != S_HUNT) && (cnt_q == C_TIMEOUT)) begin
            ev_stuck = 1'b1;
            to_hunt  = 1'b1;
        end else begin
            case (state_q)
                S_HUNT: begin
                    if (p1_q) begin
                        state_d = S_P1;
                        cnt_d   = C_CNT_ONE;
                    end
                end
                S_P1: begin
                    if (!p1_q) begin
                        ev_width = (cnt_q != C_HIGH_W);
                        state_d  = S_G1;
                        cnt_d    = C_CNT_ONE;
                    end
                end
                S_G1: begin
                    if (p1_q) begin
                        ev_order = 1'b1;
                        to_hunt  = 1'b1;
                    end else if (p2_q) begin
                        ev_width = (cnt_q != C_GAP_W);
                        state_d  = S_P2;
                        cnt_d    = C_CNT_ONE;
                    end
                end
                S_P2: begin
                    if (!p2_q) begin
                        ev_width = (cnt_q != C_HIGH_W);
                        state_d  = S_G2;
                        cnt_d    = C_CNT_ONE;
                    end
                end
                S_G2: begin
                    if (p2_q) begin
                        ev_order = 1'b1;
                        to_hunt  = 1'b1;
                    end else if (p1_q) begin
                        ev_width = (cnt_q != C_GAP_W);
                        complete = 1'b1;
                        state_d  = S_P1;
                        cnt_d    = C_CNT_ONE;
                    end
                end
                default: begin
                    to_hunt = 1'b1;
                end
            endcase
        end

        if (to_hunt) begin
            state_d = S_HUNT;
            cnt_d   = C_CNT_ONE;
        end

        // A completion closes the current cycle; a width fault elsewhere
        // taints the cycle in progress so its completion will not count.
        if (complete) begin
            bad_d = 1'b0;
            if (!bad_q && !ev_width && (good_run_q != C_LOCK)) begin
                good_run_d = good_run_q + C_RUN_ONE;
            end
        end else if (ev_width) begin
            bad_d = 1'b1;
        end

        if (ev_overlap || ev_order || ev_width || ev_stuck || to_hunt) begin
            good_run_d = '0;
        end
        if (to_hunt) begin
            bad_d = 1'b0;
        end

        p1_d          = phi1;
        p2_d          = phi2;
        tick_d        = complete;
        cycle_count_d = cycle_count_q + {C_CYC_ZERO[CNT_W-1:1], complete};
        locked_d      = (good_run_d == C_LOCK);

        // A fresh fault in the same cycle as a clear keeps its flag set.
        err_overlap_d = (err_overlap_q & ~err_clr) | ev_overlap;
        err_order_d   = (err_order_q   & ~err_clr) | ev_order;
        err_width_d   = (err_width_q   & ~err_clr) | ev_width;
        err_stuck_d   = (err_stuck_q   & ~err_clr) | ev_stuck;
    end

    // State, input capture and registered outputs with asynchronous reset.
    always_ff @(posedge clk or negedge rl) begin
        if (!rl) begin
            state_q       <= S_HUNT;
            cnt_q         <= '0;
            good_run_q    <= '0;
            bad_q         <= 1'b0;
            p1_q          <= 1'b0;
            p2_q          <= 1'b0;
            locked_q      <= 1'b0;
            tick_q        <= 1'b0;
            cycle_count_q <= '0;
            err_overlap_q <= 1'b0;
            err_order_q   <= 1'b0;
            err_width_q   <= 1'b0;
            err_stuck_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            good_run_q    <= good_run_d;
            bad_q         <= bad_d;
            p1_q          <= p1_d;
            p2_q          <= p2_d;
            locked_q      <= locked_d;
            tick_q        <= tick_d;
            cycle_count_q <= cycle_count_d;
            err_overlap_q <= err_overlap_d;
            err_order_q   <= err_order_d;
            err_width_q   <= err_width_d;
            err_stuck_q   <= err_stuck_d;
        end
    end

    assign locked      = locked_q;
    assign tick        = tick_q;
    assign cycle_count = cycle_count_q;
    assign err_overlap = err_overlap_q;
    assign err_order   = err_order_q;
    assign err_width   = err_width_q;
    assign err_stuck   = err_stuck_q;

endmodule
`default_nettype wire

// File: tb/tb_tia_biphase_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_tia_biphase_checker
// Brief    : Self-checking bench for tia_biphase_checker. Directed scenarios
//            and random phase patterns are compared every clock against a
//            phase-sequence reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tia_biphase_checker;

    localparam int HIGH_W      = 1;
    localparam int GAP_W       = 1;
    localparam int LOCK_CYCLES = 4;
    localparam int TIMEOUT     = 16;

    logic        clk;
    logic        rl;
    logic        phi1;
    logic        phi2;
    logic        err_clr;

    logic        locked, tick, err_overlap, err_order, err_width, err_stuck;
    logic [15:0] cycle_count;
    logic        locked4, tick4, err_overlap4, err_order4, err_width4, err_stuck4;
    logic [3:0]  cycle_count4;

    int errors = 0;
    int checks = 0;
    int step_no = 0;

    tia_biphase_checker dut (
        .clk(clk), .rl(rl), .phi1(phi1), .phi2(phi2), .err_clr(err_clr),
        .locked(locked), .tick(tick), .cycle_count(cycle_count),
        .err_overlap(err_overlap), .err_order(err_order),
        .err_width(err_width), .err_stuck(err_stuck)
    );

    tia_biphase_checker #(.CNT_W(4)) dut4 (
        .clk(clk), .rl(rl), .phi1(phi1), .phi2(phi2), .err_clr(err_clr),
        .locked(locked4), .tick(tick4), .cycle_count(cycle_count4),
        .err_overlap(err_overlap4), .err_order(err_order4),
        .err_width(err_width4), .err_stuck(err_stuck4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: phase index 0 = hunting, 1 = phi1 high,
    // 2 = gap after phi1, 3 = phi2 high, 4 = gap after phi2.
    // ------------------------------------------------------------------
    int m_phase, m_len, m_run, m_cycles;
    bit m_sp1, m_sp2, m_taint, m_tick, m_locked;
    bit m_fov, m_ford, m_fwid, m_fstk;

    function automatic int sat_inc(input int v, input int lim);
        return (v >= lim) ? lim : v + 1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_len = 0; m_run = 0; m_cycles = 0;
        m_sp1 = 0; m_sp2 = 0; m_taint = 0; m_tick = 0; m_locked = 0;
        m_fov = 0; m_ford = 0; m_fwid = 0; m_fstk = 0;
    endtask

    task automatic model_step(input bit clr);
        bit ov, od, wd, st, done, hunt, own, want, other;
        ov = m_sp1 && m_sp2;
        od = 0; wd = 0; done = 0;
        st = !ov && (m_phase != 0) && (m_len == TIMEOUT);
        hunt = ov || st;
        if (!hunt) begin
            if (m_phase == 0) begin
                if (m_sp1) begin m_phase = 1; m_len = 1; end
            end else if (m_phase % 2 == 1) begin
                own = (m_phase == 1) ? m_sp1 : m_sp2;
                if (own) m_len = sat_inc(m_len, TIMEOUT);
                else begin
                    wd = (m_len != HIGH_W);
                    m_phase = m_phase + 1;
                    m_len = 1;
                end
            end else begin
                want  = (m_phase == 2) ? m_sp2 : m_sp1;
                other = (m_phase == 2) ? m_sp1 : m_sp2;
                if (other) begin
                    od = 1; hunt = 1;
                end else if (want) begin
                    wd = (m_len != GAP_W);
                    done = (m_phase == 4);
                    m_phase = (m_phase % 4) + 1;
                    m_len = 1;
                end else m_len = sat_inc(m_len, TIMEOUT);
            end
        end
        if (hunt) begin m_phase = 0; m_len = 1; end
        if (done) begin
            if (!m_taint && !wd) m_run = (m_run + 1 > LOCK_CYCLES) ? LOCK_CYCLES : m_run + 1;
            m_taint = 0;
        end else if (wd) m_taint = 1;
        if (ov || od || wd || st || hunt) m_run = 0;
        if (hunt) m_taint = 0;
        m_fov  = (m_fov  && !clr) || ov;
        m_ford = (m_ford && !clr) || od;
        m_fwid = (m_fwid && !clr) || wd;
        m_fstk = (m_fstk && !clr) || st;
        m_tick = done;
        if (done) m_cycles++;
        m_locked = (m_run == LOCK_CYCLES);
        m_sp1 = phi1;
        m_sp2 = phi2;
    endtask

    // ------------------------------------------------------------------
    // Comparison helpers
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("locked",      32'(locked),      32'(m_locked));
        chk("tick",        32'(tick),        32'(m_tick));
        chk("cycle_count", 32'(cycle_count), 32'(m_cycles % 65536));
        chk("err_overlap", 32'(err_overlap), 32'(m_fov));
        chk("err_order",   32'(err_order),   32'(m_ford));
        chk("err_width",   32'(err_width),   32'(m_fwid));
        chk("err_stuck",   32'(err_stuck),   32'(m_fstk));
        chk("cnt4_locked", 32'(locked4),     32'(m_locked));
        chk("cnt4_tick",   32'(tick4),       32'(m_tick));
        chk("cnt4_count",  32'(cycle_count4), 32'(m_cycles % 16));
        chk("cnt4_flags",  32'({err_overlap4, err_order4, err_width4, err_stuck4}),
                           32'({m_fov, m_ford, m_fwid, m_fstk}));
    endtask

    // One clock of stimulus: inputs change at negedge, checked 1 after posedge.
    task automatic cyc(input bit a, input bit b, input bit clr);
        @(negedge clk);
        phi1 = a; phi2 = b; err_clr = clr;
        @(posedge clk);
        step_no++;
        model_step(clr);
        #1 check_all();
    endtask

    // One generator period with given high/gap widths; optional clear on last gap clock.
    task automatic pcycle(input int h1, input int g1, input int h2, input int g2, input bit clr);
        for (int i = 0; i < h1; i++) cyc(1, 0, 0);
        for (int i = 0; i < g1; i++) cyc(0, 0, 0);
        for (int i = 0; i < h2; i++) cyc(0, 1, 0);
        for (int i = 0; i < g2; i++) cyc(0, 0, clr && (i == g2 - 1));
    endtask

    task automatic nominal(input int n);
        for (int i = 0; i < n; i++) pcycle(1, 1, 1, 1, 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rl = 1'b1; phi1 = 0; phi2 = 0; err_clr = 0;
        @(posedge clk);
        step_no++;
        model_step(0);
        #1 check_all();
    endtask

    function automatic int rw();
        return ($urandom_range(0, 7) == 0) ? 2 : 1;
    endfunction

    initial begin
        int r;
        rl = 1'b0; phi1 = 0; phi2 = 0; err_clr = 0;
        model_reset();
        #1 check_all();
        repeat (2) @(posedge clk);
        release_reset();

        // Nominal: ten generator periods.
        nominal(10);
        chk("nom_count", 32'(cycle_count), 32'd9);
        chk("nom_locked", 32'(locked), 32'd1);
        chk("nom_errs", 32'({err_overlap, err_order, err_width, err_stuck}), 32'd0);

        // Overlap after lock, then recovery.
        cyc(1, 1, 0);
        cyc(0, 0, 0);
        chk("ovl_flag", 32'(err_overlap), 32'd1);
        chk("ovl_unlock", 32'(locked), 32'd0);
        nominal(6);
        chk("ovl_relock", 32'(locked), 32'd1);
        chk("ovl_sticky", 32'(err_overlap), 32'd1);

        // Clear on the last gap clock of a clean period.
        pcycle(1, 1, 1, 1, 1);
        chk("clr_flags", 32'({err_overlap, err_order, err_width, err_stuck}), 32'd0);

        // Stretched phi2.
        pcycle(1, 1, 2, 1, 0);
        pcycle(1, 1, 1, 1, 0);
        chk("wid_flag", 32'(err_width), 32'd1);
        chk("wid_unlock", 32'(locked), 32'd0);

        // phi1 rises where phi2 was expected.
        cyc(1, 0, 0); cyc(0, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);
        chk("ord_flag", 32'(err_order), 32'd1);

        // phi1 held high.
        for (int i = 0; i < 20; i++) cyc(1, 0, 0);
        chk("stk_flag", 32'(err_stuck), 32'd1);
        cyc(0, 0, 0);

        // Clear colliding with a fresh overlap.
        cyc(1, 1, 0);
        cyc(0, 0, 1);
        chk("col_overlap", 32'(err_overlap), 32'd1);
        chk("col_others", 32'({err_order, err_width, err_stuck}), 32'd0);

        // Enough periods to wrap the 4-bit counter.
        nominal(20);

        // Random phase patterns.
        for (int i = 0; i < 150; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 65) pcycle(rw(), rw(), rw(), rw(), $urandom_range(0, 15) == 0);
            else if (r < 75) cyc(1, 1, 0);
            else cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 7) == 0);
        end

        // Asynchronous reset in the middle of phi2.
        nominal(2);
        cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 1, 0); cyc(0, 0, 0);
        #1 rl = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("arst_count", 32'(cycle_count), 32'd0);
        release_reset();
        nominal(1);
        chk("arst_first", 32'(cycle_count), 32'd0);
        nominal(1);
        chk("arst_second", 32'(cycle_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
